// File: rtl/uart_mmio_buffer_pkg.sv
// Shared constants for the CPU-side UART endpoint: default byte width,
// the memory-mapped UART addresses and the status bit positions the CPU polls.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic [31:0] UART_CTRL_ADDR    = 32'h8000_0000;
    localparam logic [31:0] UART_STATUS_ADDR  = 32'h8000_0004;
    localparam logic [31:0] UART_TX_DATA_ADDR = 32'h8000_0008;
    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h8000_000C;

    // bit0 of the TX control word is DataInReady, bit0 of the RX control word is DataOutValid
    localparam int UART_TX_READY_BIT = 0;
    localparam int UART_RX_VALID_BIT = 0;

endpackage

// File: rtl/uart_mmio_buffer_if.sv
// Handshake bundle between the CPU UART decode, the UART tx/rx cores and the buffer.
// The slave view is the buffer itself; the master view is its environment.
interface uart_mmio_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  DataInValid;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  DataInReady;
    logic                  DataOutValid;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  DataOutReady;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  clear_flags;
    logic [CNT_W-1:0]      tx_count;
    logic [CNT_W-1:0]      rx_count;
    logic                  tx_overflow;
    logic                  rx_overflow;

    modport slave (
        input  DataInValid, DataIn, DataOutReady, tx_ready, rx_valid, rx_data, clear_flags,
        output DataInReady, DataOutValid, DataOut, tx_valid, tx_data,
               tx_count, rx_count, tx_overflow, rx_overflow
    );

    modport master (
        output DataInValid, DataIn, DataOutReady, tx_ready, rx_valid, rx_data, clear_flags,
        input  DataInReady, DataOutValid, DataOut, tx_valid, tx_data,
               tx_count, rx_count, tx_overflow, rx_overflow
    );

endinterface

// File: rtl/uart_mmio_buffer_sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO. Head is read combinationally at the
// read pointer and forced to zero while empty so uninitialised storage never leaks.
// A push while full is accepted only if a pop frees the slot on the same edge.
module sync_fifo_fwft
    import uart_pkg::*;
#(
    parameter int  DEPTH      = 8,
    parameter int  DATA_WIDTH = UART_DATA_WIDTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int CNT_W      = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow_event
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign valid          = (r_count != '0);
    assign full           = (r_count == CNT_W'(DEPTH));
    assign w_do_pop       = pop && valid;
    assign w_do_push      = push && (!full || w_do_pop);
    assign overflow_event = push && !w_do_push;
    assign head           = valid ? r_mem[r_rd_ptr] : '0;
    assign count          = r_count;

    // Storage write on every accepted push; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy only moves when exactly one side acts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_buffer.sv
// UART-side endpoint of the CPU memory-mapped UART: a TX FIFO from CPU stores to
// the transmitter, an RX FIFO from the receiver to CPU loads, and sticky overflow flags.
module uart_mmio_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_mmio_buffer_if.slave bus
);

    logic w_tx_full;
    logic w_tx_push;
    logic w_tx_ovf_evt;
    logic w_tx_drop;
    logic w_rx_full;
    logic w_rx_ovf_evt;
    logic r_tx_overflow;
    logic r_rx_overflow;

    // DataInReady comes from the registered count only, so a store while full is
    // dropped even when the transmitter pops on the same edge.
    assign bus.DataInReady = !w_tx_full;
    assign w_tx_push       = bus.DataInValid && bus.DataInReady;
    // The FIFO's own event stays low for the pre-gated TX push; OR-ing it in keeps
    // the flag correct if the gating above is ever relaxed.
    assign w_tx_drop       = (bus.DataInValid && !bus.DataInReady) || w_tx_ovf_evt;

    sync_fifo_fwft #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_fifo (
        .clk            (clk),
        .reset_n        (reset_n),
        .push           (w_tx_push),
        .push_data      (bus.DataIn),
        .pop            (bus.tx_ready),
        .head           (bus.tx_data),
        .valid          (bus.tx_valid),
        .full           (w_tx_full),
        .count          (bus.tx_count),
        .overflow_event (w_tx_ovf_evt)
    );

    sync_fifo_fwft #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx_fifo (
        .clk            (clk),
        .reset_n        (reset_n),
        .push           (bus.rx_valid),
        .push_data      (bus.rx_data),
        .pop            (bus.DataOutReady),
        .head           (bus.DataOut),
        .valid          (bus.DataOutValid),
        .full           (w_rx_full),
        .count          (bus.rx_count),
        .overflow_event (w_rx_ovf_evt)
    );

    // Sticky overflow flags: a drop in the same cycle as clear_flags keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_overflow <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            if (w_tx_drop) begin
                r_tx_overflow <= 1'b1;
            end else if (bus.clear_flags) begin
                r_tx_overflow <= 1'b0;
            end
            if (w_rx_ovf_evt) begin
                r_rx_overflow <= 1'b1;
            end else if (bus.clear_flags) begin
                r_rx_overflow <= 1'b0;
            end
        end
    end

    assign bus.tx_overflow = r_tx_overflow;
    assign bus.rx_overflow = r_rx_overflow;

    // Full status is exposed to the CPU through counts; kept here for readability.
    logic w_unused_rx_full;
    assign w_unused_rx_full = w_rx_full;

endmodule

// File: tb/tb_uart_mmio_buffer.sv
// Directed bench for uart_mmio_buffer: queues hold the bytes expected from each FIFO,
// pushed when stimulus is accepted and popped when the DUT hands the byte out.
module tb_uart_mmio_buffer;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    uart_mmio_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    uart_mmio_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    bit            tx_ovf_m;
    bit            rx_ovf_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the scoreboard state.
    task automatic verify_state(input string tag);
        check({tag, ".tx_count"},     32'(bus.tx_count),     32'(tx_q.size()));
        check({tag, ".rx_count"},     32'(bus.rx_count),     32'(rx_q.size()));
        check({tag, ".tx_valid"},     32'(bus.tx_valid),     32'(tx_q.size() != 0));
        check({tag, ".DataOutValid"}, 32'(bus.DataOutValid), 32'(rx_q.size() != 0));
        check({tag, ".DataInReady"},  32'(bus.DataInReady),  32'(tx_q.size() != DEPTH));
        check({tag, ".tx_overflow"},  32'(bus.tx_overflow),  32'(tx_ovf_m));
        check({tag, ".rx_overflow"},  32'(bus.rx_overflow),  32'(rx_ovf_m));
        check({tag, ".tx_data"},      32'(bus.tx_data),      (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'h0);
        check({tag, ".DataOut"},      32'(bus.DataOut),      (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'h0);
    endtask

    // One clock of stimulus: drive, update scoreboard from pre-edge state, clock, verify.
    task automatic step(input string tag, input bit div, input logic [DW-1:0] di, input bit txr,
                        input bit rxv, input logic [DW-1:0] rxd, input bit dor, input bit clr);
        bit tx_pop, tx_acc, rx_pop, rx_acc;
        bus.DataInValid  = div;
        bus.DataIn       = di;
        bus.tx_ready     = txr;
        bus.rx_valid     = rxv;
        bus.rx_data      = rxd;
        bus.DataOutReady = dor;
        bus.clear_flags  = clr;
        tx_pop = txr && (tx_q.size() != 0);
        tx_acc = div && (tx_q.size() != DEPTH);
        rx_pop = dor && (rx_q.size() != 0);
        rx_acc = rxv && ((rx_q.size() != DEPTH) || rx_pop);
        if (tx_pop) begin
            check({tag, ".tx_out"}, 32'(bus.tx_data), 32'(tx_q.pop_front()));
        end
        if (tx_acc) tx_q.push_back(di);
        if (rx_pop) begin
            check({tag, ".rx_out"}, 32'(bus.DataOut), 32'(rx_q.pop_front()));
        end
        if (rx_acc) rx_q.push_back(rxd);
        if (div && !tx_acc) tx_ovf_m = 1'b1;
        else if (clr)       tx_ovf_m = 1'b0;
        if (rxv && !rx_acc) rx_ovf_m = 1'b1;
        else if (clr)       rx_ovf_m = 1'b0;
        @(posedge clk);
        #1;
        bus.DataInValid  = 1'b0;
        bus.tx_ready     = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.DataOutReady = 1'b0;
        bus.clear_flags  = 1'b0;
        verify_state(tag);
    endtask

    initial begin
        bus.DataInValid  = 1'b0;
        bus.DataIn       = '0;
        bus.tx_ready     = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = '0;
        bus.DataOutReady = 1'b0;
        bus.clear_flags  = 1'b0;
        tx_ovf_m = 1'b0;
        rx_ovf_m = 1'b0;

        // reset state
        #12;
        verify_state("reset");
        #11;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        verify_state("post_reset");

        // three stores held, then drained in order
        step("st41", 1, 8'h41, 0, 0, 0, 0, 0);
        step("st42", 1, 8'h42, 0, 0, 0, 0, 0);
        step("st43", 1, 8'h43, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("drain3", 0, 0, 1, 0, 0, 0, 0);

        // fill TX, overflow with 0xFF, drain, clear
        for (int i = 0; i < DEPTH; i++) step("fill_tx", 1, 8'(8'hA0 + i), 0, 0, 0, 0, 0);
        step("tx_ovf", 1, 8'hFF, 0, 0, 0, 0, 0);
        step("tx_full_pushpop", 1, 8'hFE, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step("drain_tx", 0, 0, 1, 0, 0, 0, 0);
        step("tx_clr", 0, 0, 0, 0, 0, 0, 1);

        // RX basic, including pop while empty
        step("rx10", 0, 0, 0, 1, 8'h10, 0, 0);
        step("rx20", 0, 0, 0, 1, 8'h20, 0, 0);
        step("pop1", 0, 0, 0, 0, 0, 1, 0);
        step("pop2", 0, 0, 0, 0, 0, 1, 0);
        step("pop_empty", 0, 0, 0, 0, 0, 1, 0);

        // RX full with concurrent push/pop, then overflow, set-wins, clear
        for (int i = 0; i < DEPTH; i++) step("fill_rx", 0, 0, 0, 1, 8'(8'h60 + i), 0, 0);
        step("rx_full_pushpop", 0, 0, 0, 1, 8'h99, 1, 0);
        step("rx_ovf", 0, 0, 0, 1, 8'hAA, 0, 0);
        step("rx_setwins", 0, 0, 0, 1, 8'hBB, 0, 1);
        step("rx_clr", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step("drain_rx", 0, 0, 0, 0, 0, 1, 0);

        // concurrent TX streaming, pointers wrap
        for (int i = 0; i < 20; i++) step("stream", 1, 8'(i), 1, 0, 0, 0, 0);
        step("stream_end", 0, 0, 1, 0, 0, 0, 0);

        // asynchronous reset with both FIFOs at 5
        for (int i = 0; i < 5; i++) step("fill5", 1, 8'(8'hC0 + i), 0, 1, 8'(8'hD0 + i), 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        tx_q.delete();
        rx_q.delete();
        tx_ovf_m = 1'b0;
        rx_ovf_m = 1'b0;
        verify_state("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        verify_state("rst_release");
        step("after_rst_push", 1, 8'h5A, 0, 1, 8'hA5, 0, 0);
        step("after_rst_pop", 0, 0, 1, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
